// File: rtl/anim_pkg.sv
// Shared types and constants for the sprite walk-cycle scheduler.
package anim_pkg;

  typedef logic [1:0] step_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } sched_state_t;

  localparam step_t STEP_MAX = 2'd3;

endpackage

// File: rtl/step_update_unit.sv
// Combinational next-state for one object's divider and step count; shared across objects.
module step_update_unit
  import anim_pkg::*;
#(
  parameter int unsigned STEP_DIV = 8,
  parameter int unsigned DIV_W    = 4
) (
  input  logic [DIV_W-1:0] div_i,
  input  step_t            step_i,
  input  logic             moving_i,
  input  logic             active_i,
  output logic [DIV_W-1:0] div_o,
  output step_t            step_o
);

  always_comb begin
    div_o  = '0;
    step_o = '0;
    if (!active_i) begin
      div_o  = '0;
      step_o = '0;
    end else if (!moving_i) begin
      // Standing pose.
      div_o  = '0;
      step_o = '0;
    end else if (div_i == DIV_W'(STEP_DIV - 1)) begin
      div_o  = '0;
      step_o = (step_i == STEP_MAX) ? step_t'(0) : step_i + step_t'(1);
    end else begin
      div_o  = div_i + DIV_W'(1);
      step_o = step_i;
    end
  end

endmodule

// File: rtl/step_anim_scheduler.sv
// Time-multiplexed walk-cycle scheduler: one shared update unit walks all objects per frame tick.
// Optional STEP_TICK_QUEUE_EN keeps one pending tick that arrives while a scan is busy.
module step_anim_scheduler
  import anim_pkg::*;
#(
  parameter int unsigned NUM_OBJ  = 4,
  parameter int unsigned STEP_DIV = 8,
  parameter int unsigned DIV_W    = 4,
  localparam int unsigned IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Frame_Tick,
  input  logic [NUM_OBJ-1:0]   Obj_Moving,
  input  logic [NUM_OBJ-1:0]   Obj_Active,
  input  logic [IDX_W-1:0]     Rd_Idx,
  output logic [1:0]           Rd_Step,
  output logic [2*NUM_OBJ-1:0] Obj_Step_All,
  output logic                 Busy,
  output logic                 Update_Done
);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OBJ-1:0] moving_q, active_q;
  logic               snap_en;
  step_t              step_q [NUM_OBJ];
  logic [DIV_W-1:0]   div_q  [NUM_OBJ];
  step_t              step_nxt;
  logic [DIV_W-1:0]   div_nxt;

`ifdef STEP_TICK_QUEUE_EN
  logic pending_q, pending_d;
`endif

  step_update_unit #(
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) u_update (
    .div_i    (div_q[idx_q]),
    .step_i   (step_q[idx_q]),
    .moving_i (moving_q[idx_q]),
    .active_i (active_q[idx_q]),
    .div_o    (div_nxt),
    .step_o   (step_nxt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (Frame_Tick) begin
          state_d = SCAN;
          idx_d   = '0;
          snap_en = 1'b1;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef STEP_TICK_QUEUE_EN
        // A tick landing in DONE is served by the same restart as a queued one.
        if (pending_q || Frame_Tick) begin
          state_d = SCAN;
          idx_d   = '0;
          snap_en = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STEP_TICK_QUEUE_EN
  always_comb begin
    pending_d = pending_q;
    if (state_q == SCAN && Frame_Tick) begin
      pending_d = 1'b1;
    end else if (state_q == DONE) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      moving_q <= '0;
      active_q <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        step_q[i] <= '0;
        div_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (snap_en) begin
        moving_q <= Obj_Moving;
        active_q <= Obj_Active;
      end
      if (state_q == SCAN) begin
        step_q[idx_q] <= step_nxt;
        div_q[idx_q]  <= div_nxt;
      end
    end
  end

  always_comb begin
    Rd_Step = '0;
    if ({1'b0, Rd_Idx} < (IDX_W + 1)'(NUM_OBJ)) begin
      Rd_Step = step_q[Rd_Idx];
    end
  end

  always_comb begin
    Obj_Step_All = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      Obj_Step_All[2*i +: 2] = step_q[i];
    end
  end

  assign Busy        = (state_q != IDLE);
  assign Update_Done = (state_q == DONE);

endmodule

// File: tb/tb_step_anim_scheduler.sv
// Randomized self-checking bench; reference model counts consecutive moving frames per object.
module tb_step_anim_scheduler;

  localparam int unsigned NUM_OBJ  = 4;
  localparam int unsigned STEP_DIV = 8;
  localparam int unsigned DIV_W    = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Frame_Tick;
  logic [3:0] Obj_Moving;
  logic [3:0] Obj_Active;
  logic [1:0] Rd_Idx;
  logic [1:0] Rd_Step;
  logic [7:0] Obj_Step_All;
  logic       Busy;
  logic       Update_Done;

  int n_tests = 0;
  int n_fail  = 0;
  // Consecutive active+moving frames per object; step = (run / STEP_DIV) mod 4.
  int m_run [NUM_OBJ];

  step_anim_scheduler #(
    .NUM_OBJ  (NUM_OBJ),
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Frame_Tick   (Frame_Tick),
    .Obj_Moving   (Obj_Moving),
    .Obj_Active   (Obj_Active),
    .Rd_Idx       (Rd_Idx),
    .Rd_Step      (Rd_Step),
    .Obj_Step_All (Obj_Step_All),
    .Busy         (Busy),
    .Update_Done  (Update_Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] m_packed();
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < NUM_OBJ; i++) p[2*i +: 2] = 2'((m_run[i] / STEP_DIV) % 4);
    return p;
  endfunction

  task automatic model_frame(input logic [3:0] mv, input logic [3:0] ac);
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (mv[i] && ac[i]) m_run[i] = m_run[i] + 1;
      else                m_run[i] = 0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_OBJ; i++) m_run[i] = 0;
  endtask

  // mode 0: inputs held, 1: toggle Obj_Moving[2] every scan cycle, 2: random inputs during scan.
  task automatic run_scan(input logic [3:0] mv, input logic [3:0] ac, input int mode);
    logic [7:0] old_p, new_p, exp_p;
    old_p = m_packed();
    Obj_Moving = mv;
    Obj_Active = ac;
    Frame_Tick = 1'b1;
    model_frame(mv, ac);
    new_p = m_packed();
    cyc();
    Frame_Tick = 1'b0;
    for (int k = 1; k <= NUM_OBJ; k++) begin
      if (mode == 1) Obj_Moving[2] = ~Obj_Moving[2];
      if (mode == 2) begin
        Obj_Moving = 4'($urandom);
        Obj_Active = 4'($urandom);
      end
      exp_p = old_p;
      for (int i = 0; i < NUM_OBJ; i++) if (i + 2 <= k) exp_p[2*i +: 2] = new_p[2*i +: 2];
      check("scan_busy", Busy, 1);
      check("scan_done", Update_Done, 0);
      check("scan_steps", Obj_Step_All, exp_p);
      cyc();
    end
    Rd_Idx = 2'($urandom);
    #1;
    check("done_pulse", Update_Done, 1);
    check("done_busy", Busy, 1);
    check("done_steps", Obj_Step_All, new_p);
    check("rd_step", Rd_Step, new_p[2*Rd_Idx +: 2]);
    cyc();
    check("idle_busy", Busy, 0);
    check("idle_done", Update_Done, 0);
  endtask

  initial begin
    bit q_en;
    logic [3:0] mv, ac;
`ifdef STEP_TICK_QUEUE_EN
    q_en = 1'b1;
`else
    q_en = 1'b0;
`endif
    model_clear();
    Reset      = 1'b1;
    Frame_Tick = 1'b0;
    Obj_Moving = '0;
    Obj_Active = '0;
    Rd_Idx     = '0;
    cyc();
    cyc();
    check("rst_busy", Busy, 0);
    check("rst_done", Update_Done, 0);
    check("rst_steps", Obj_Step_All, 0);
    check("rst_rd", Rd_Step, 0);
    Reset = 1'b0;
    cyc();

    // No objects active: busy for NUM_OBJ+1 cycles, all steps zero.
    run_scan(4'b0000, 4'b0000, 0);

    // Player walking: step advances every STEP_DIV ticks and wraps after four steps.
    for (int n = 1; n <= 32; n++) begin
      run_scan(4'b0001, 4'b0001, 0);
      if (n == 7)  check("p0_tick7", Obj_Step_All[1:0], 0);
      if (n == 8)  check("p0_tick8", Obj_Step_All[1:0], 1);
      if (n == 31) check("p0_tick31", Obj_Step_All[1:0], 3);
      if (n == 32) check("p0_wrap", Obj_Step_All[1:0], 0);
    end

    // Object 1 reaches step 2, stops (pose and divider cleared), then resumes from zero.
    for (int n = 0; n < 16; n++) run_scan(4'b0010, 4'b0010, 0);
    check("o1_step2", Obj_Step_All[3:2], 2);
    run_scan(4'b0000, 4'b0010, 0);
    check("o1_stop", Obj_Step_All[3:2], 0);
    for (int n = 0; n < 7; n++) run_scan(4'b0010, 4'b0010, 0);
    check("o1_div_clr", Obj_Step_All[3:2], 0);
    run_scan(4'b0010, 4'b0010, 0);
    check("o1_resume", Obj_Step_All[3:2], 1);

    // Snapshot: toggling Obj_Moving[2] mid-scan must not matter.
    for (int n = 0; n < 10; n++) run_scan(4'b0100, 4'b0100, 1);
    check("o2_snap", Obj_Step_All[5:4], 1);

    // Reset mid-scan aborts with no partial results or done pulse.
    Obj_Moving = 4'b1111;
    Obj_Active = 4'b1111;
    Frame_Tick = 1'b1;
    cyc();
    Frame_Tick = 1'b0;
    cyc();
    cyc();
    Reset = 1'b1;
    cyc();
    model_clear();
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Update_Done, 0);
    check("mid_rst_steps", Obj_Step_All, 0);
    Reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      check("mid_rst_nodone", Update_Done, 0);
      check("mid_rst_idle", Busy, 0);
    end

    // Second tick two cycles into a scan: dropped, or queued when the queue is built in.
    for (int n = 0; n < 7; n++) run_scan(4'b1111, 4'b1111, 0);
    Obj_Moving = 4'b1111;
    Obj_Active = 4'b1111;
    Frame_Tick = 1'b1;
    model_frame(4'b1111, 4'b1111);
    if (q_en) model_frame(4'b1111, 4'b1111);
    cyc();
    for (int c = 1; c <= 11; c++) begin
      Frame_Tick = (c == 2);
      if (q_en) begin
        check("q_busy", Busy, (c <= 10));
        check("q_done", Update_Done, (c == 5 || c == 10));
      end else begin
        check("q_busy", Busy, (c <= 5));
        check("q_done", Update_Done, (c == 5));
      end
      if (c < 11) cyc();
    end
    check("q_steps", Obj_Step_All, m_packed());

    // Randomized frames with random disturbances during each scan.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        mv[i] = ($urandom_range(0, 7) != 0);
        ac[i] = ($urandom_range(0, 15) != 0);
      end
      run_scan(mv, ac, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_anim_scheduler.md
Name: step_anim_scheduler

Overview:
- Time-multiplexed walk-cycle scheduler for all sprites (player plus zombies) in the boxhead game.
- Owns one 2-bit step count (frames 0..3) and one frame divider per object.
- On each video-frame tick, walks the objects one per clock through a single shared update unit.
- Feeds the sprite ROM address logic, which reads step counts by index or packed.

Parameters:
- NUM_OBJ, 4, number of animated objects; index 0 is the player.
- STEP_DIV, 8, video frames per walk step; legal range >= 1.
- DIV_W, 4, divider counter width; must satisfy 2**DIV_W >= STEP_DIV.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Frame_Tick  in  1  one-cycle pulse per video frame (vsync edge, already synchronized to Clk).
- Obj_Moving  in  NUM_OBJ  per-object moving flag.
- Obj_Active  in  NUM_OBJ  per-object alive flag.
- Rd_Idx  in  $clog2(NUM_OBJ)  read index.
- Rd_Step  out  2  step count of object Rd_Idx, combinational read.
- Obj_Step_All  out  2*NUM_OBJ  packed step counts; object i occupies bits [2i+1:2i].
- Busy  out  1  high while a scan is in progress.
- Update_Done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (synchronous, active-high; clock Clk):
  - FSM goes to IDLE.
  - All step[i], div[i] and the index are cleared to 0.
  - Busy=0, Update_Done=0, Rd_Step=0, Obj_Step_All=0.
  - Reset asserted mid-scan aborts the scan immediately; no partial results are kept.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If Frame_Tick=1, snapshot Obj_Moving and Obj_Active into internal registers, set idx=0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN: update exactly object idx each cycle, using the snapshot values, in this priority order:
  - Not active: div=0, step=0.
  - Active but not moving: div=0, step=0 (standing pose).
  - Moving and div==STEP_DIV-1: div=0, step=step+1 mod 4 (3 wraps to 0).
  - Moving otherwise: div=div+1, step unchanged.
  - If idx==NUM_OBJ-1, go to DONE; otherwise idx=idx+1.
- DONE: Update_Done=1 for this single cycle, then go to IDLE.
- Busy=1 in SCAN and DONE, 0 in IDLE.
- Timing, for a Frame_Tick sampled in cycle t:
  - SCAN runs cycles t+1 .. t+NUM_OBJ.
  - The new value of object i is visible from cycle t+2+i.
  - DONE (Update_Done high) is cycle t+1+NUM_OBJ.
  - The FSM is back in IDLE at t+2+NUM_OBJ.
- Input changes during a scan have no effect, because the snapshot is used.
- STEP_DIV=1: step advances every frame while moving; div stays 0.
- Frame_Tick while Busy=1: dropped unless the optional feature is enabled.
- Rd_Idx >= NUM_OBJ (non-power-of-two NUM_OBJ): Rd_Step=0.
- Step count is 2-bit unsigned with modular wrap. The divider never exceeds STEP_DIV-1.

Optional Feature:
- Macro: STEP_TICK_QUEUE_EN.
- Defined:
  - A Frame_Tick arriving while Busy=1 sets a 1-deep pending flag.
  - On leaving DONE with the flag set, the FSM goes directly to SCAN, clears the flag, and takes a fresh snapshot.
  - Further ticks arriving while the flag is already set are lost.
- Undefined: ticks arriving while Busy=1 are discarded and there is no pending flag.

Decomposition:
- Package anim_pkg:
  - typedef step_t (logic [1:0]).
  - enum sched_state_t {IDLE, SCAN, DONE}.
  - constant STEP_MAX=3.
- Sub-module step_update_unit: purely combinational.
  - Inputs: div, step, moving, active.
  - Outputs: next div, next step.
  - Instantiated once and shared across objects by the scan index.

Test Plan (NUM_OBJ=4, STEP_DIV=8):
1. Reset, then one Frame_Tick with no objects active -> Busy high for 5 cycles, Update_Done pulses at t+5, Obj_Step_All=0.
2. Obj0 active and moving; 8 ticks -> step0 stays 0 after ticks 1-7 and becomes 1 after tick 8; 32 ticks -> step0 wraps 3->0.
3. Obj1 moving with step1=2; Obj_Moving[1] deasserted before the next tick -> after that scan, step1=0 and div1=0.
4. Toggle Obj_Moving[2] during SCAN -> no effect this scan (snapshot); the change applies at the next tick.
5. Reset asserted at t+3 mid-scan -> next cycle IDLE, Busy=0, all steps 0, no Update_Done pulse.
6. Frame_Tick at t and t+2 -> without STEP_TICK_QUEUE_EN, one scan only; with it, a second scan starts at t+6 and Update_Done pulses at t+5 and t+10.
